// File: rtl/mvu_pkg.sv
// ---------------------------------------------------------------------------
// mvu_pkg: shared definitions for the MVU APB CSR path.
//   - APB address/data widths, MVU count, CSR offsets
//   - apb_cmd_t      : one queued CSR write {addr, data}
//   - cmdq_state_t   : APB master sequencing states
//   - mvu_id()       : MVU select field of an APB address (also used by the
//                      CSR slave decode, so both sides agree on the split)
// ---------------------------------------------------------------------------
package mvu_pkg;

    localparam int APB_ADDR_WIDTH = 15;
    localparam int APB_DATA_WIDTH = 32;
    localparam int N              = 4;
    localparam int MVU_ID_WIDTH   = APB_ADDR_WIDTH - 12;

    localparam logic [11:0] CSR_MVUWBASEPTR = 12'h020;
    localparam logic [11:0] CSR_MVUCOMMAND  = 12'h0F0;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] data;
    } apb_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } cmdq_state_t;

    function automatic logic [MVU_ID_WIDTH-1:0] mvu_id(input logic [APB_ADDR_WIDTH-1:0] addr);
        return addr[APB_ADDR_WIDTH-1:12];
    endfunction

endpackage

// File: rtl/mvu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// mvu_cmd_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n      : clock, async active-low reset (flushes pointers/level)
//   push_i, wdata_i : write request and data (ignored when full)
//   pop_i           : discard head (ignored when empty)
//   rdata_o         : current head, valid whenever empty_o = 0
//   level_o         : registered occupancy 0..DEPTH
//   full_o, empty_o : occupancy flags decoded from level_o
// ---------------------------------------------------------------------------
module mvu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;
    logic             push_s;
    logic             pop_s;

    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_s) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_s) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/mvu_apb_cmdq.sv
// ---------------------------------------------------------------------------
// mvu_apb_cmdq: APB master command queue feeding the MVU CSR slave.
//   clk, rst_n                 : clock, async active-low reset
//   cmd_valid_i/cmd_ready_o    : host command stream handshake
//   cmd_addr_i, cmd_data_i     : CSR write address (MVU id | offset) and data
//   mvu_done_i                 : per-MVU job-done pulses
//   paddr_o..pwdata_o          : APB write master (pwrite_o tied high)
//   pready_i, pslverr_i        : APB slave response
//   mvu_busy_o                 : per-MVU job-in-flight flags
//   fifo_level_o               : queued entries, head included until it completes
//   err_o / err_clr_i          : sticky error (bad MVU id or slave error) and clear
// The queue entry type comes from mvu_pkg, so the address/data parameters are
// expected to stay at their package defaults.
// ---------------------------------------------------------------------------
module mvu_apb_cmdq #(
    parameter int APB_ADDR_WIDTH = mvu_pkg::APB_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH = 32,
    parameter int NMVU           = mvu_pkg::N,
    parameter int DEPTH          = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] cmd_data_i,
    input  logic [NMVU-1:0]           mvu_done_i,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic                      pready_i,
    input  logic                      pslverr_i,
    output logic [NMVU-1:0]           mvu_busy_o,
    output logic [$clog2(DEPTH):0]    fifo_level_o,
    output logic                      err_o,
    input  logic                      err_clr_i
);
    import mvu_pkg::*;

    localparam int IDW = APB_ADDR_WIDTH - 12;

    cmdq_state_t               state_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      psel_q;
    logic                      penable_q;
    logic [NMVU-1:0]           mvu_busy_q;
    logic                      err_q;
    logic                      head_vld_q;

    apb_cmd_t                  push_cmd_s;
    apb_cmd_t                  head_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic                      push_s;
    logic                      pop_s;
    logic [IDW-1:0]            id_s;
    logic                      id_ok_s;
    logic                      is_cmd_s;
    logic [NMVU-1:0]           id_hot_s;
    logic                      busy_hit_s;
    logic                      head_ok_s;
    logic                      drop_s;
    logic                      xfer_done_s;
    logic [NMVU-1:0]           busy_set_s;

    assign cmd_ready_o     = !fifo_full_s;
    assign push_s          = cmd_valid_i && cmd_ready_o;
    assign push_cmd_s.addr = cmd_addr_i;
    assign push_cmd_s.data = cmd_data_i;

    mvu_cmd_fifo #(
        .WIDTH ($bits(apb_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (push_cmd_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .level_o (fifo_level_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Head decode: target MVU, its busy state, and whether this write starts a job.
    always_comb begin
        id_hot_s = '0;
        id_s     = mvu_id(head_s.addr);
        id_ok_s  = (int'(id_s) < NMVU);
        is_cmd_s = (head_s.addr[11:0] == CSR_MVUCOMMAND);
        for (int i = 0; i < NMVU; i++) begin
            id_hot_s[i] = (int'(id_s) == i);
        end
        busy_hit_s = |(id_hot_s & mvu_busy_q);
    end

    // Issue/completion qualifiers. head_vld_q gives a newly written entry one
    // settle cycle before decode; back-to-back entries are not delayed by it.
    always_comb begin
        head_ok_s   = head_vld_q && !fifo_empty_s;
        drop_s      = (state_q == IDLE) && head_ok_s && !id_ok_s;
        xfer_done_s = (state_q == ACCESS) && pready_i;
        pop_s       = drop_s || xfer_done_s;
        if (xfer_done_s && !pslverr_i && is_cmd_s) begin
            busy_set_s = id_hot_s;
        end else begin
            busy_set_s = '0;
        end
    end

    // APB master sequencer with registered bus outputs, busy and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            mvu_busy_q <= '0;
            err_q      <= 1'b0;
            head_vld_q <= 1'b0;
        end else begin
            head_vld_q <= !fifo_empty_s;
            // Set wins over a same-edge done pulse for the same MVU.
            mvu_busy_q <= (mvu_busy_q & ~mvu_done_i) | busy_set_s;
            if (drop_s || (xfer_done_s && pslverr_i)) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_q;
            end
            case (state_q)
                IDLE: begin
                    if (head_ok_s && id_ok_s && !busy_hit_s) begin
                        state_q   <= SETUP;
                        paddr_q   <= head_s.addr;
                        pwdata_q  <= head_s.data;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready_i) begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end else begin
                        state_q <= ACCESS;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign paddr_o    = paddr_q;
    assign pwdata_o   = pwdata_q;
    assign psel_o     = psel_q;
    assign penable_o  = penable_q;
    assign pwrite_o   = 1'b1;
    assign mvu_busy_o = mvu_busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_mvu_apb_cmdq.sv
`timescale 1ns/1ps
module tb_mvu_apb_cmdq;
    import mvu_pkg::*;

    localparam int AW    = mvu_pkg::APB_ADDR_WIDTH;
    localparam int DW    = 32;
    localparam int NM    = mvu_pkg::N;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [NM-1:0] mvu_done;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic          pslverr;
    logic [NM-1:0] mvu_busy;
    logic [LW-1:0] fifo_level;
    logic          err;
    logic          err_clr;

    int n_vec  = 0;
    int n_fail = 0;

    mvu_apb_cmdq #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .NMVU           (NM),
        .DEPTH          (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_data_i   (cmd_data),
        .mvu_done_i   (mvu_done),
        .paddr_o      (paddr),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .pwdata_o     (pwdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr),
        .mvu_busy_o   (mvu_busy),
        .fifo_level_o (fifo_level),
        .err_o        (err),
        .err_clr_i    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          slverr;
        logic [NM-1:0] exp_busy;
        logic          exp_err;
    } vec_t;

    vec_t          vecs [7];
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] data_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] mk_addr(input int id, input logic [11:0] ofs);
        logic [AW-1:0] a;
        a          = '0;
        a[11:0]    = ofs;
        a[AW-1:12] = (AW-12)'(id);
        return a;
    endfunction

    // Wait (bounded) until the bus sits in the ACCESS phase.
    task automatic wait_access(input string name);
        for (int k = 0; k < 20; k++) begin
            if (psel && penable) break;
            tick();
        end
        check(name, {63'd0, psel && penable}, 64'd1);
    endtask

    task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        vecs[0] = '{mk_addr(1, CSR_MVUWBASEPTR), 32'h0000_00A5, 1'b0, 4'b0000, 1'b0};
        vecs[1] = '{mk_addr(0, CSR_MVUWBASEPTR), 32'h1234_5678, 1'b0, 4'b0000, 1'b0};
        vecs[2] = '{mk_addr(3, 12'h004),         32'hDEAD_BEEF, 1'b0, 4'b0000, 1'b0};
        vecs[3] = '{mk_addr(1, CSR_MVUCOMMAND),  32'h0000_0001, 1'b0, 4'b0010, 1'b0};
        vecs[4] = '{mk_addr(3, CSR_MVUCOMMAND),  32'h0000_0002, 1'b0, 4'b1000, 1'b0};
        vecs[5] = '{mk_addr(2, CSR_MVUCOMMAND),  32'h0000_0003, 1'b1, 4'b0000, 1'b1};
        vecs[6] = '{mk_addr(0, 12'h0FF),         32'hFFFF_FFFF, 1'b1, 4'b0000, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        mvu_done = '0; pready = 1'b0; pslverr = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        check("rst_psel",   {63'd0, psel},      64'd0);
        check("rst_ready",  {63'd0, cmd_ready}, 64'd1);
        check("rst_level",  64'(fifo_level),    64'd0);
        check("rst_busy",   64'(mvu_busy),      64'd0);
        check("rst_err",    {63'd0, err},       64'd0);
        check("rst_pwrite", {63'd0, pwrite},    64'd1);
        rst_n = 1'b1;
        tick();

        // Table: single write into empty queue; psel after E+2, complete at E+4.
        for (int v = 0; v < 7; v++) begin
            pready  = 1'b1;
            pslverr = vecs[v].slverr;
            push1(vecs[v].addr, vecs[v].data);
            check("v_lvl1",  64'(fifo_level), 64'd1);
            check("v_e1",    {63'd0, psel},   64'd0);
            tick();
            check("v_e2",    {63'd0, psel},   64'd0);
            tick();
            check("v_setup", {62'd0, psel, penable}, 64'd2);
            check("v_paddr", 64'(paddr),  64'(vecs[v].addr));
            check("v_pwdata",64'(pwdata), 64'(vecs[v].data));
            tick();
            check("v_access",{62'd0, psel, penable}, 64'd3);
            tick();
            check("v_idle",  {62'd0, psel, penable}, 64'd0);
            check("v_lvl0",  64'(fifo_level), 64'd0);
            check("v_busy",  64'(mvu_busy), 64'(vecs[v].exp_busy));
            check("v_err",   {63'd0, err},  {63'd0, vecs[v].exp_err});
            pslverr  = 1'b0;
            mvu_done = '1;
            err_clr  = 1'b1;
            tick();
            mvu_done = '0;
            err_clr  = 1'b0;
            check("v_clean", {59'd0, mvu_busy, err}, 64'd0);
        end

        // Busy MVU blocks the head; later entries wait in order.
        pready = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr = mk_addr(2, CSR_MVUCOMMAND);  cmd_data = 32'h11; tick();
        cmd_addr = mk_addr(2, CSR_MVUWBASEPTR); cmd_data = 32'h22; tick();
        cmd_addr = mk_addr(3, CSR_MVUWBASEPTR); cmd_data = 32'h33; tick();
        cmd_valid = 1'b0;
        wait_access("hol_first_access");
        tick();
        check("hol_busy2", 64'(mvu_busy),   64'h4);
        check("hol_level", 64'(fifo_level), 64'd2);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (psel) cnt++;
        end
        check("hol_blocked", 64'(cnt), 64'd0);
        mvu_done = 4'b0100;
        tick();
        mvu_done = '0;
        check("hol_cleared", 64'(mvu_busy), 64'd0);
        addr_q.delete();
        for (int k = 0; k < 20; k++) begin
            if (psel && !penable) addr_q.push_back(paddr);
            tick();
        end
        check("hol_count", 64'(addr_q.size()), 64'd2);
        if (addr_q.size() == 2) begin
            check("hol_order0", 64'(addr_q[0]), 64'(mk_addr(2, CSR_MVUWBASEPTR)));
            check("hol_order1", 64'(addr_q[1]), 64'(mk_addr(3, CSR_MVUWBASEPTR)));
        end
        check("hol_drained", 64'(fifo_level), 64'd0);

        // Wait states: bus stable through 5 pready-low cycles, single pop after.
        pready = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr = mk_addr(1, CSR_MVUWBASEPTR); cmd_data = 32'hA0A0_0001; tick();
        cmd_addr = mk_addr(0, CSR_MVUWBASEPTR); cmd_data = 32'hB0B0_0002; tick();
        cmd_valid = 1'b0;
        wait_access("ws_access");
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ws_stable", {15'd0, psel, penable, paddr, pwdata},
                  {15'd0, 1'b1, 1'b1, mk_addr(1, CSR_MVUWBASEPTR), 32'hA0A0_0001});
            check("ws_level", 64'(fifo_level), 64'd2);
        end
        pready = 1'b1;
        tick();
        check("ws_done",   {63'd0, psel},   64'd0);
        check("ws_onepop", 64'(fifo_level), 64'd1);
        wait_access("ws_second");
        check("ws_second_addr", 64'(paddr), 64'(mk_addr(0, CSR_MVUWBASEPTR)));
        tick();
        check("ws_empty", 64'(fifo_level), 64'd0);

        // Full FIFO: 9th command held until the first completion frees a slot.
        pready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = mk_addr(i % NM, CSR_MVUWBASEPTR);
            cmd_data  = DW'(i);
            check("full_ready", {63'd0, cmd_ready}, 64'd1);
            tick();
        end
        cmd_addr = mk_addr(1, CSR_MVUWBASEPTR);
        cmd_data = 32'd8;
        check("full_level", 64'(fifo_level), 64'd8);
        check("full_nready", {63'd0, cmd_ready}, 64'd0);
        tick(); tick(); tick();
        check("full_held", 64'(fifo_level), 64'd8);
        pready = 1'b1;
        data_q.delete();
        if (psel && penable) data_q.push_back(pwdata);
        tick();
        check("full_pop", 64'(fifo_level), 64'd7);
        check("full_ready_again", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
        check("full_refill", 64'(fifo_level), 64'd8);
        for (int k = 0; k < 60; k++) begin
            if (psel && penable) data_q.push_back(pwdata);
            if (fifo_level == '0 && !psel) break;
            tick();
        end
        check("full_count", 64'(data_q.size()), 64'd9);
        for (int i = 0; i < data_q.size() && i < 9; i++) begin
            check("full_order", 64'(data_q[i]), 64'(i));
        end

        // Bad MVU id: dropped without bus activity, sticky err; set beats clear.
        pready = 1'b1;
        push1(mk_addr(NM, CSR_MVUWBASEPTR), 32'h5);
        check("drop_lvl1", 64'(fifo_level), 64'd1);
        tick();
        check("drop_pre", {62'd0, psel, err}, 64'd0);
        tick();
        check("drop_psel", {63'd0, psel}, 64'd0);
        check("drop_lvl0", 64'(fifo_level), 64'd0);
        check("drop_err",  {63'd0, err},  64'd1);
        tick(); tick();
        check("drop_sticky", {62'd0, psel, err}, 64'd1);
        push1(mk_addr(7, 12'h123), 32'h6);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("drop_setwins", {63'd0, err}, 64'd1);
        check("drop2_lvl0", 64'(fifo_level), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {63'd0, err}, 64'd0);

        // Async reset mid-ACCESS with a busy MVU and queued work.
        pready = 1'b1;
        push1(mk_addr(0, CSR_MVUCOMMAND), 32'h7);
        wait_access("rst_pre_access");
        tick();
        check("rst_pre_busy", 64'(mvu_busy), 64'h1);
        pready = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr = mk_addr(1, CSR_MVUWBASEPTR); cmd_data = 32'h77; tick();
        cmd_addr = mk_addr(2, CSR_MVUWBASEPTR); cmd_data = 32'h78; tick();
        cmd_valid = 1'b0;
        wait_access("rst_mid_access");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bus",   {62'd0, psel, penable}, 64'd0);
        check("arst_busy",  64'(mvu_busy),   64'd0);
        check("arst_paddr", 64'(paddr),      64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst", {61'd0, cmd_ready, psel, err}, 64'd4);
        check("post_rst_level", 64'(fifo_level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
